// File: rtl/hpdmc_idelay_ctl.sv
// Control-pin sequencer for the HPDMC IODELAY2 pair: turns reset/calibrate/step requests into
// spaced RST/CAL/CE/INC pulses and mirrors the tap. Optional BUSY handshake: HPDMC_IODELAY_BUSY_EN.
module hpdmc_idelay_ctl #(
  parameter int TAP_MAX   = 255,
  parameter int CAL_WAIT  = 16,
  parameter int PULSE_GAP = 4
) (
  input  logic       sys_clk,
  input  logic       sdram_rst,
  input  logic       req_rst,
  input  logic       req_cal,
  input  logic       req_inc,
  input  logic       req_dec,
  input  logic [7:0] req_steps,
`ifdef HPDMC_IODELAY_BUSY_EN
  input  logic       dly_busy,
`endif
  output logic       busy,
  output logic       done,
  output logic       sat,
  output logic [7:0] tap,
  output logic       dly_rst,
  output logic       dly_cal,
  output logic       dly_ce,
  output logic       dly_inc,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_RESET, S_RST, S_CAL, S_WAIT, S_STEP, S_GAP, S_DONE, S_IDLE
  } state_t;

  localparam int CNT_MAX = (CAL_WAIT > PULSE_GAP) ? CAL_WAIT : PULSE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [7:0]    TAP_TOP  = TAP_MAX[7:0];
  localparam logic [CW-1:0] GAP_LOAD = CW'(PULSE_GAP - 1);
`ifdef HPDMC_IODELAY_BUSY_EN
  // Minimum two WAIT cycles so BUSY has time to rise after the CAL/RST pulse.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(1);
`else
  localparam logic [CW-1:0] WAIT_LOAD = CW'(CAL_WAIT - 1);
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    steps_q, steps_d;
  logic          dir_q, dir_d;
  logic [7:0]    tap_q, tap_d;
  logic          sat_q, sat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rst_q, rst_d;
  logic          cal_q, cal_d;
  logic          ce_q, ce_d;
  logic          inc_q, inc_d;
  logic          bound;
  logic          timer_idle;

`ifdef HPDMC_IODELAY_BUSY_EN
  assign timer_idle = (cnt_q == '0) && !dly_busy;
`else
  assign timer_idle = (cnt_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    tap_d   = tap_q;
    sat_d   = sat_q;
    rst_d   = 1'b0;
    cal_d   = 1'b0;
    ce_d    = 1'b0;
    inc_d   = 1'b0;
    done_d  = 1'b0;
    bound   = 1'b0;

    case (state_q)
      S_RESET: state_d = S_RST;
      S_RST, S_CAL: begin
        state_d = S_WAIT;
        cnt_d   = WAIT_LOAD;
      end
      S_WAIT: begin
        if (timer_idle) state_d = S_DONE;
        else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      // sat_q can only be set here by the entry check, so it flags "bound hit this step".
      S_STEP: begin
        if (sat_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (timer_idle) state_d = (steps_q != 8'd0) ? S_STEP : S_DONE;
        else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      S_DONE: state_d = S_IDLE;
      S_IDLE: begin
        if (req_rst) begin
          state_d = S_RST;
          sat_d   = 1'b0;
        end else if (req_cal) begin
          state_d = S_CAL;
          sat_d   = 1'b0;
        end else if (req_inc || req_dec) begin
          sat_d   = 1'b0;
          dir_d   = req_inc;
          steps_d = req_steps;
          state_d = (req_steps == 8'd0) ? S_DONE : S_STEP;
        end
      end
      default: state_d = S_RESET;
    endcase

    // RST, CAL, STEP and DONE last one cycle, so entering them is keyed on state_d alone;
    // the pulse outputs are registered together with the state.
    case (state_d)
      S_RST: begin
        rst_d = 1'b1;
        tap_d = 8'd0;
      end
      S_CAL: cal_d = 1'b1;
      S_STEP: begin
        bound = dir_d ? (tap_q == TAP_TOP) : (tap_q == 8'd0);
        if (bound) begin
          sat_d = 1'b1;
        end else begin
          ce_d    = 1'b1;
          inc_d   = dir_d;
          tap_d   = dir_d ? (tap_q + 8'd1) : (tap_q - 8'd1);
          steps_d = steps_d - 8'd1;
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_RESET);
  end

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      steps_q <= 8'd0;
      dir_q   <= 1'b0;
      tap_q   <= 8'd0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      cal_q   <= 1'b0;
      ce_q    <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      tap_q   <= tap_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_q   <= rst_d;
      cal_q   <= cal_d;
      ce_q    <= ce_d;
      inc_q   <= inc_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sat         = sat_q;
  assign tap         = tap_q;
  assign dly_rst     = rst_q;
  assign dly_cal     = cal_q;
  assign dly_ce      = ce_q;
  assign dly_inc     = inc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hpdmc_idelay_ctl.sv
// Bench for hpdmc_idelay_ctl: per-cycle output trace compared against a phase-level model
// of each request (pulse, wait/gap lengths, tap arithmetic, saturation), with random requests.
module tb_hpdmc_idelay_ctl;
  localparam int TAP_MAX   = 255;
  localparam int CAL_WAIT  = 16;
  localparam int PULSE_GAP = 4;
  localparam int K_RST = 0, K_CAL = 1, K_INC = 2, K_DEC = 3;
`ifdef HPDMC_IODELAY_BUSY_EN
  localparam int WAIT_LEN = 2;
`else
  localparam int WAIT_LEN = CAL_WAIT;
`endif

  // clock/reset block
  logic sys_clk = 1'b0;
  logic sdram_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic       req_rst = 1'b0, req_cal = 1'b0, req_inc = 1'b0, req_dec = 1'b0;
  logic [7:0] req_steps = 8'd0;
`ifdef HPDMC_IODELAY_BUSY_EN
  logic       dly_busy = 1'b0;
`endif
  logic       busy, done, sat, dly_rst, dly_cal, dly_ce, dly_inc;
  logic [7:0] tap;
  logic [2:0] dbg_state;

  hpdmc_idelay_ctl #(.TAP_MAX(TAP_MAX), .CAL_WAIT(CAL_WAIT), .PULSE_GAP(PULSE_GAP)) dut (
    .sys_clk     (sys_clk),
    .sdram_rst   (sdram_rst),
    .req_rst     (req_rst),
    .req_cal     (req_cal),
    .req_inc     (req_inc),
    .req_dec     (req_dec),
    .req_steps   (req_steps),
`ifdef HPDMC_IODELAY_BUSY_EN
    .dly_busy    (dly_busy),
`endif
    .busy        (busy),
    .done        (done),
    .sat         (sat),
    .tap         (tap),
    .dly_rst     (dly_rst),
    .dly_cal     (dly_cal),
    .dly_ce      (dly_ce),
    .dly_inc     (dly_inc),
    .dbg_state_o (dbg_state)
  );

  // observed word: {busy, done, sat, tap[7:0], rst, cal, ce, inc}
  logic [14:0] obs;
  assign obs = {busy, done, sat, tap, dly_rst, dly_cal, dly_ce, dly_inc};

  logic [14:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  m_tap = 8'd0;
  logic        m_sat = 1'b0;

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (busy,done,sat,tap,rst,cal,ce,inc) t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic b, input logic d, input logic [3:0] p);
    exp_q.push_back({b, d, m_sat, m_tap, p});
  endfunction

  // Expected trace for cycles 1.. after a request accepted in IDLE (or after reset release),
  // ending with the first IDLE cycle.
  function automatic void model_op(input int kind, input int steps);
    int   left;
    logic up;
    m_sat = 1'b0;
    if (kind == K_RST || kind == K_CAL) begin
      if (kind == K_RST) m_tap = 8'd0;
      push(1'b1, 1'b0, (kind == K_RST) ? 4'b1000 : 4'b0100);
      repeat (WAIT_LEN) push(1'b1, 1'b0, 4'b0000);
    end else begin
      up   = (kind == K_INC);
      left = steps;
      while (left > 0) begin
        if (up ? (int'(m_tap) == TAP_MAX) : (m_tap == 8'd0)) begin
          m_sat = 1'b1;
          push(1'b1, 1'b0, 4'b0000);
          left = 0;
        end else begin
          m_tap = up ? 8'(m_tap + 8'd1) : 8'(m_tap - 8'd1);
          push(1'b1, 1'b0, {3'b001, up});
          left--;
          repeat (PULSE_GAP) push(1'b1, 1'b0, 4'b0000);
        end
      end
    end
    push(1'b1, 1'b1, 4'b0000);
    push(1'b0, 1'b0, 4'b0000);
  endfunction

  task automatic idle_reqs();
    req_rst = 1'b0; req_cal = 1'b0; req_inc = 1'b0; req_dec = 1'b0;
    req_steps = 8'd0;
  endtask

  // requests while busy must be ignored
  task automatic junk_reqs();
    req_rst = 1'($urandom_range(0, 1)); req_cal = 1'($urandom_range(0, 1));
    req_inc = 1'($urandom_range(0, 1)); req_dec = 1'($urandom_range(0, 1));
    req_steps = 8'($urandom_range(0, 255));
  endtask

  task automatic drain(input string tag, input int abort_at);
    int k = 0;
    while (exp_q.size() > 0) begin
      @(posedge sys_clk); #1;
      k++;
      if (exp_q[0][14]) junk_reqs(); else idle_reqs();
      check_eq($sformatf("%s_c%0d", tag, k), obs, exp_q.pop_front());
      if (k == abort_at) exp_q.delete();
    end
  endtask

  // noise: 0 none, 1 random, 2 all lower-priority requests also raised
  task automatic run_op(input int kind, input int steps, input int noise, input int abort_at);
    logic n;
    model_op(kind, steps);
    n = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    req_rst   = (kind == K_RST);
    req_cal   = (kind == K_CAL) || (kind < K_CAL && n);
    req_inc   = (kind == K_INC) || (kind < K_INC && n);
    req_dec   = (kind == K_DEC) || (kind < K_DEC && (noise == 2 || 1'($urandom_range(0, 1)) && n));
    req_steps = (kind >= K_INC) ? 8'(steps) : 8'($urandom_range(1, 255));
    drain($sformatf("op%0d_s%0d", kind, steps), abort_at);
  endtask

  task automatic do_reset(input int hold);
    sdram_rst = 1'b1;
    idle_reqs();
    m_tap = 8'd0;
    m_sat = 1'b0;
    repeat (hold) begin
      @(posedge sys_clk); #1;
      check_eq("in_reset", obs, 15'h0000);
    end
    sdram_rst = 1'b0;
    model_op(K_RST, 0);
    drain("post_reset", 0);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog got=running exp=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, steps, noise, abort_at;
    do_reset(3);
    run_op(K_INC, 2, 0, 0);
    run_op(K_CAL, 0, 2, 0);
    run_op(K_INC, 252, 0, 0);
    run_op(K_INC, 5, 0, 0);
    run_op(K_DEC, 1, 0, 0);
    run_op(K_INC, 0, 0, 0);
    run_op(K_RST, 0, 2, 0);
    run_op(K_DEC, 3, 0, 0);
    run_op(K_INC, 10, 0, 3);
    do_reset(2);

    for (int i = 0; i < 60; i++) begin
      kind     = $urandom_range(0, 3);
      steps    = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 20);
      noise    = $urandom_range(0, 1);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 30) : 0;
      run_op(kind, steps, noise, abort_at);
      if (abort_at != 0) do_reset($urandom_range(1, 3));
    end

`ifdef HPDMC_IODELAY_BUSY_EN
    begin
      int k = 0;
      model_op(K_CAL, 0);
      exp_q.delete();
      push(1'b1, 1'b0, 4'b0100);
      repeat (30) push(1'b1, 1'b0, 4'b0000);
      push(1'b1, 1'b1, 4'b0000);
      push(1'b0, 1'b0, 4'b0000);
      req_cal = 1'b1;
      while (exp_q.size() > 0) begin
        @(posedge sys_clk); #1;
        k++;
        idle_reqs();
        dly_busy = (k >= 1 && k <= 30);
        check_eq($sformatf("busy_cal_c%0d", k), obs, exp_q.pop_front());
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hpdmc_idelay_ctl.md
Name: hpdmc_idelay_ctl

Overview:
- Sequencer driving the control pins (RST/CAL/CE/INC) of the DDR IODELAY2 pair in the Spartan-6 HPDMC datapath; sits directly upstream of the delay block on the CLK (sys_clk) domain.
- Turns CSR-level requests (reset, calibrate, move N taps up/down) into correctly spaced single-cycle pulses.
- Keeps a shadow tap counter mirroring the VARIABLE_FROM_ZERO delay line, reporting saturation.

Parameters:
- TAP_MAX, 255, highest legal tap value; shadow counter saturates here.
- CAL_WAIT, 16, idle cycles held after a dly_cal or dly_rst pulse before the next action.
- PULSE_GAP, 4, idle cycles after each dly_ce pulse (>=1).

Ports:
- sys_clk  in  1  system clock; also drives the delay block's CLK.
- sdram_rst  in  1  synchronous active-high reset.
- req_rst  in  1  request delay reset; sampled in IDLE only.
- req_cal  in  1  request calibration; sampled in IDLE only.
- req_inc  in  1  request increment by req_steps; sampled in IDLE only.
- req_dec  in  1  request decrement by req_steps; sampled in IDLE only.
- req_steps  in  8  tap step count for inc/dec.
- busy  out  1  sequence in progress; requests ignored.
- done  out  1  one-cycle pulse at sequence end.
- sat  out  1  sticky: last inc/dec hit a bound; cleared on next accepted request.
- tap  out  8  shadow tap value.
- dly_rst  out  1  to delay RST.
- dly_cal  out  1  to delay CAL.
- dly_ce  out  1  to delay CE.
- dly_inc  out  1  to delay INC.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sdram_rst is synchronous and active-high.
- Reset values: while sdram_rst is high, all outputs are 0, tap=0, and the state machine is held in RESET.
- Automatic reset sequence: on the first cycle after sdram_rst falls, the block enters RST, so the hardware delay line matches tap=0.
- States: RESET, RST, CAL, WAIT, STEP, GAP, DONE, IDLE.
- RST: dly_rst=1 for exactly one cycle, tap<=0, then go to WAIT.
- CAL: dly_cal=1 for exactly one cycle, then go to WAIT. tap is unchanged.
- WAIT: counts CAL_WAIT cycles, then goes to DONE.
- IDLE: samples requests. Priority is rst > cal > inc > dec; lower-priority requests in the same cycle are dropped.
  - An accepted request clears sat.
  - inc/dec loads a step counter from req_steps.
  - req_steps=0 goes straight to DONE with no pulse.
- STEP:
  - If the move would cross a bound (tap==TAP_MAX on inc, or tap==0 on dec), set sat=1, issue no pulse, and go to DONE.
  - Otherwise assert dly_ce=1 for one cycle. dly_inc=1 for an increment, 0 for a decrement.
  - tap updates on the same edge, by ±1.
  - Decrement the step counter and go to GAP.
- GAP: PULSE_GAP cycles with dly_ce=0. Then go to STEP if steps remain, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy: high in every state except IDLE and RESET. This includes the automatic post-reset sequence.
- Pulse rule: dly_inc is 0 in every cycle that dly_ce is 0. dly_rst, dly_cal and dly_ce are mutually exclusive.
- Latency: request sampled in IDLE at cycle 0; first control pulse at cycle 1.
- Reset mid-operation: aborts immediately with the reset values; no partial pulse is extended.
- All outputs are registered.

Optional Feature:
- Macro: HPDMC_IODELAY_BUSY_EN.
- When defined:
  - Adds input dly_busy (1 bit), taken from IODELAY2 BUSY.
  - WAIT exits on the first cycle dly_busy==0, no earlier than 2 cycles after the pulse.
  - GAP exits only when both PULSE_GAP has expired and dly_busy==0.
- When undefined: fixed CAL_WAIT/PULSE_GAP timing only; there is no dly_busy port.

Test Plan:
- Release sdram_rst -> dly_rst pulses at cycle 1; busy=1 through done at cycle 1+1+CAL_WAIT (=18); then busy=0 and tap=0.
- req_inc, req_steps=2, PULSE_GAP=4, from IDLE at cycle 0 -> dly_ce&dly_inc at cycles 1 and 6; tap=1 then 2; done at cycle 11.
- tap=254, req_inc, req_steps=5 -> exactly one dly_ce pulse; tap=255; sat=1; done pulses. A following req_dec with steps=1 clears sat; tap=254.
- req_cal and req_inc asserted together in IDLE -> only dly_cal pulses, tap unchanged; done at cycle 1+CAL_WAIT+1; inc is dropped.
- sdram_rst asserted during GAP of a 10-step inc -> next cycle all outputs 0, tap=0; after release, the automatic RST sequence runs.
- With HPDMC_IODELAY_BUSY_EN, dly_busy held high for 30 cycles after dly_cal -> done appears only after dly_busy falls.
